// File: rtl/bp_defines.sv
// Shared branch-predictor definitions: 2-bit counter encodings, the counter
// value used after reset and flush, the default table size and FSM state type.
package bp_defines;

    localparam int DEFAULT_IDX_W = 6;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    localparam logic [1:0] CNT_RESET = 2'(WNT);

    typedef enum logic {
        S_IDLE,
        S_FLUSH
    } pht_state_e;

endpackage

// File: rtl/sat2_next.sv
// Two-bit saturating counter step: taken counts up to ST,
// not-taken counts down to SNT.
module sat2_next
    import bp_defines::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_cnt
);

    always_comb begin
        o_cnt = i_cnt;
        if (i_taken) begin
            if (i_cnt != 2'(ST)) begin
                o_cnt = i_cnt + 2'd1;
            end
        end else begin
            if (i_cnt != 2'(SNT)) begin
                o_cnt = i_cnt - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pattern_history_table.sv
// Pattern history table of 2^IDX_W two-bit counters with a one-deep write stage,
// read bypass and a flush sweep. Define PHT_GSHARE_EN to XOR a global history into the index.
module pattern_history_table
    import bp_defines::*;
#(
    parameter int IDX_W = DEFAULT_IDX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pred_valid,
    input  logic [31:0] pred_pc,
    output logic        pred_resp_valid,
    output logic        pred_taken,
    output logic [1:0]  pred_cnt,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic        flush,
    output logic        busy
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]       r_table [DEPTH];
    pht_state_e       r_state;
    logic             r_busy;
    logic [IDX_W-1:0] r_sweep;

    logic             r_ws_valid;
    logic [IDX_W-1:0] r_ws_idx;
    logic             r_ws_taken;

    logic             r_pred_resp_valid;
    logic [1:0]       r_pred_cnt;

    logic             w_flush_acc;
    logic             w_pred_acc;
    logic             w_upd_acc;
    logic             w_ws_write;
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [1:0]       w_ws_cur;
    logic [1:0]       w_ws_next;
    logic [1:0]       w_pred_val;
    logic             w_unused;

    assign w_flush_acc = flush & (r_state == S_IDLE);
    assign w_pred_acc  = pred_valid & ~r_busy;
    assign w_upd_acc   = upd_valid & ~r_busy & ~w_flush_acc;

`ifdef PHT_GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    assign w_pred_idx = pred_pc[IDX_W+1:2] ^ r_ghr;
    assign w_upd_idx  = upd_pc[IDX_W+1:2] ^ r_ghr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_flush_acc) begin
            r_ghr <= '0;
        end else if (w_upd_acc) begin
            r_ghr <= IDX_W'({r_ghr, upd_taken});
        end
    end
`else
    assign w_pred_idx = pred_pc[IDX_W+1:2];
    assign w_upd_idx  = upd_pc[IDX_W+1:2];
`endif

    assign w_unused = ^{pred_pc[31:IDX_W+2], pred_pc[1:0], upd_pc[31:IDX_W+2], upd_pc[1:0]};

    // Write stage: read-modify-write one cycle after the update is accepted.
    assign w_ws_cur   = r_table[r_ws_idx];
    assign w_ws_write = r_ws_valid & ~w_flush_acc;

    sat2_next u_sat2_next (
        .i_cnt   (w_ws_cur),
        .i_taken (r_ws_taken),
        .o_cnt   (w_ws_next)
    );

    // A pending write to the same entry is newer than the array contents.
    assign w_pred_val = (r_ws_valid && (r_ws_idx == w_pred_idx)) ? w_ws_next
                                                                 : r_table[w_pred_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_sweep <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_state <= S_FLUSH;
                        r_busy  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_sweep <= r_sweep + 1'b1;
                    if (r_sweep == '1) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= CNT_RESET;
            end
        end else if (r_state == S_FLUSH) begin
            r_table[r_sweep] <= CNT_RESET;
        end else if (w_ws_write) begin
            r_table[r_ws_idx] <= w_ws_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ws_valid <= 1'b0;
            r_ws_idx   <= '0;
            r_ws_taken <= 1'b0;
        end else begin
            r_ws_valid <= w_upd_acc;
            if (w_upd_acc) begin
                r_ws_idx   <= w_upd_idx;
                r_ws_taken <= upd_taken;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_resp_valid <= 1'b0;
            r_pred_cnt        <= 2'(SNT);
        end else begin
            r_pred_resp_valid <= w_pred_acc;
            if (w_pred_acc) begin
                r_pred_cnt <= w_pred_val;
            end
        end
    end

    assign pred_resp_valid = r_pred_resp_valid;
    assign pred_cnt        = r_pred_cnt;
    assign pred_taken      = r_pred_cnt[1];
    assign busy            = r_busy;

endmodule

// File: tb/tb_pattern_history_table.sv
// Self-checking bench for pattern_history_table (default build, IDX_W=6):
// vector table for predict/update behaviour plus hand sequences for flush and reset.
module tb_pattern_history_table;

    logic        clk;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic [1:0]  pred_cnt;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        flush;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0] sb_q [$];

    typedef struct {
        logic        pv;
        logic [31:0] ppc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [1:0]  ec;
    } vec_t;

    vec_t vecs [24];

    pattern_history_table #(.IDX_W(6)) dut (
        .clk             (clk),
        .reset           (reset),
        .pred_valid      (pred_valid),
        .pred_pc         (pred_pc),
        .pred_resp_valid (pred_resp_valid),
        .pred_taken      (pred_taken),
        .pred_cnt        (pred_cnt),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .flush           (flush),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; acc says whether the bench expects the prediction to be accepted.
    task automatic drive_cycle(input logic pv, input logic [31:0] ppc, input logic uv,
                               input logic [31:0] upc, input logic ut, input logic fl,
                               input logic acc, input logic [1:0] ec);
        logic [1:0] e;
        pred_valid = pv;
        pred_pc    = ppc;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        flush      = fl;
        if (acc) sb_q.push_back(ec);
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        upd_valid  = 1'b0;
        flush      = 1'b0;
        check("resp_valid", 32'(pred_resp_valid), 32'(acc));
        if (acc) begin
            e = sb_q.pop_front();
            check("pred_cnt", 32'(pred_cnt), 32'(e));
            check("pred_taken", 32'(pred_taken), 32'(e[1]));
            $display("[TB] pred pc=%08h cnt=%b taken=%b", ppc, pred_cnt, pred_taken);
        end
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    // Start a flush (with a pred in the accept cycle) and count busy cycles while
    // hammering ignored pred/upd/flush requests.
    task automatic flush_and_count(input logic [31:0] pre_pc, input logic [1:0] pre_cnt);
        int cnt;
        drive_cycle(1'b1, pre_pc, 1'b1, 32'h40, 1'b1, 1'b1, 1'b1, pre_cnt);
        check("busy_after_flush", 32'(busy), 32'd1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            cnt++;
            drive_cycle(1'b1, 32'h44, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 2'b00);
        end
        check("busy_cycles", 32'(cnt), 32'd64);
        $display("[TB] flush busy for %0d cycles", cnt);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 2'b01};
        vecs[1]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 2'b00};
        vecs[2]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 2'b00};
        vecs[3]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 2'b00};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 2'b00};
        vecs[5]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 2'b11};
        vecs[6]  = '{1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 2'b11};
        vecs[7]  = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 2'b00};
        vecs[9]  = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 2'b00};
        vecs[10] = '{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 2'b00};
        vecs[11] = '{1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 2'b00};
        vecs[12] = '{1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 2'b00};
        vecs[13] = '{1'b0, 32'h0,   1'b1, 32'h40,  1'b1, 2'b00};
        vecs[14] = '{1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 2'b10};
        vecs[15] = '{1'b1, 32'h44,  1'b1, 32'h44,  1'b1, 2'b01};
        vecs[16] = '{1'b1, 32'h44,  1'b0, 32'h0,   1'b0, 2'b10};
        vecs[17] = '{1'b1, 32'h48,  1'b1, 32'h48,  1'b0, 2'b01};
        vecs[18] = '{1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 2'b00};
        vecs[19] = '{1'b1, 32'h48,  1'b0, 32'h0,   1'b0, 2'b00};
        vecs[20] = '{1'b0, 32'h0,   1'b1, 32'hFC,  1'b1, 2'b00};
        vecs[21] = '{1'b0, 32'h0,   1'b1, 32'hFC,  1'b1, 2'b00};
        vecs[22] = '{1'b1, 32'hFC,  1'b0, 32'h0,   1'b0, 2'b11};
        vecs[23] = '{1'b1, 32'h1FC, 1'b0, 32'h0,   1'b0, 2'b11};

        reset      = 1'b1;
        pred_valid = 1'b0;
        pred_pc    = 32'h0;
        upd_valid  = 1'b0;
        upd_pc     = 32'h0;
        upd_taken  = 1'b0;
        flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_valid", 32'(pred_resp_valid), 32'd0);
        check("reset_pred_cnt", 32'(pred_cnt), 32'd0);
        check("reset_pred_taken", 32'(pred_taken), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive_cycle(vecs[i].pv, vecs[i].ppc, vecs[i].uv, vecs[i].upc, vecs[i].ut,
                        1'b0, vecs[i].pv, vecs[i].ec);
        end

        // Flush: pred in the accept cycle sees the pre-flush counter (idx 0 = 00).
        flush_and_count(32'h200, 2'b00);
        check("busy_after_sweep", 32'(busy), 32'd0);
        drive_cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);
        drive_cycle(1'b1, 32'h44,  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);
        drive_cycle(1'b1, 32'hFC,  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);
        drive_cycle(1'b1, 32'h40,  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);

        // Dirty entries beyond the part of the sweep that completes before reset.
        drive_cycle(1'b0, 32'h0, 1'b1, 32'hFC, 1'b1, 1'b0, 1'b0, 2'b00);
        drive_cycle(1'b0, 32'h0, 1'b1, 32'hFC, 1'b1, 1'b0, 1'b0, 2'b00);
        drive_cycle(1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 2'b00);
        drive_cycle(1'b1, 32'hFC, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b11);

        drive_cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00);
        for (int k = 0; k < 10; k++) idle_cycle();
        check("busy_in_sweep10", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("busy_on_reset", 32'(busy), 32'd0);
        check("resp_valid_on_reset", 32'(pred_resp_valid), 32'd0);
        check("pred_cnt_on_reset", 32'(pred_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_cycle(1'b1, 32'hFC,  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);
        drive_cycle(1'b1, 32'h80,  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);
        drive_cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);

        // A fresh flush after the aborted one must again run a full sweep.
        flush_and_count(32'h80, 2'b01);
        drive_cycle(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_history_table.md
PATTERN_HISTORY_TABLE -- requirements
Module: pattern_history_table

Interface
REQ-001 SHALL have parameter IDX_W, default 6, table index width (2^IDX_W two-bit counters).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port pred_valid  input  1  request a prediction this cycle.
REQ-005 SHALL have port pred_pc  input  32  PC of the branch to predict.
REQ-006 SHALL have port pred_resp_valid  output  1  prediction result valid, registered.
REQ-007 SHALL have port pred_taken  output  1  predicted direction (counter bit 1).
REQ-008 SHALL have port pred_cnt  output  2  counter value read.
REQ-009 SHALL have port upd_valid  input  1  resolved-branch update this cycle.
REQ-010 SHALL have port upd_pc  input  32  PC of the resolved branch.
REQ-011 SHALL have port upd_taken  input  1  actual outcome.
REQ-012 SHALL have port flush  input  1  single-cycle request to reinitialise the table.
REQ-013 SHALL have port busy  output  1  flush sweep in progress; requests ignored.

Function
REQ-014 Index SHALL be pc[IDX_W+1:2].
REQ-015 Prediction accepted (pred_valid & ~busy) in cycle N SHALL give pred_resp_valid=1, pred_cnt, pred_taken=pred_cnt[1] in cycle N+1; otherwise pred_resp_valid=0 and pred_cnt/pred_taken hold.
REQ-016 Update accepted (upd_valid & ~busy) in cycle N SHALL be latched into a write stage; in N+1 the counter is read, next value computed, written at end of N+1.
REQ-017 Next value: taken -> +1 saturating at 11; not taken -> -1 saturating at 00.
REQ-018 Back-to-back updates to one index SHALL each apply (four taken from 01 end at 11).
REQ-019 Prediction in cycle M SHALL reflect every update accepted before M: bypass write-stage result when its index matches; an update in the same cycle M is not visible.
REQ-020 FSM states IDLE, FLUSH; flush & ~busy in IDLE -> FLUSH; busy=1 from N+1 for exactly 2^IDX_W cycles, clearing entry k to 01 in sweep cycle k; then IDLE.
REQ-021 In the flush-accept cycle: upd_valid dropped, pending write-stage update discarded; a pred accepted that cycle responds with pre-flush value.
REQ-022 flush while busy SHALL be ignored; sweep counter wraps to 0 on exit.

Reset
REQ-023 Reset SHALL set all counters 01, state IDLE, busy 0, write stage empty, pred_resp_valid 0, pred_taken 0, pred_cnt 00, history 0; reset mid-flush aborts sweep with same result.

Configuration
REQ-024 With PHT_GSHARE_EN defined: IDX_W-bit global history register, index = pc[IDX_W+1:2] ^ ghr, ghr shifts in upd_taken (LSB) on each accepted update, cleared by flush; without it no history register exists and REQ-014 applies unchanged.

Structure
REQ-025 Shared package/header bp_defines SHALL hold counter encodings (SNT=00, WNT=01, WT=10, ST=11), reset value WNT and default IDX_W.
REQ-026 One sub-module sat2_next SHALL compute the saturating next value (2-bit in, taken in, 2-bit out).

Verification
REQ-027 After reset, pred pc 0x100 -> next cycle pred_resp_valid=1, pred_cnt=01, pred_taken=0.
REQ-028 Four taken updates pc 0x100 on consecutive cycles, then pred -> pred_cnt=11, pred_taken=1.
REQ-029 Two not-taken updates pc 0x200 then third -> pred_cnt=00 (saturated).
REQ-030 upd taken pc 0x40 at N, pred pc 0x40 at N+1 -> response at N+2 pred_cnt=10 (bypass).
REQ-031 Flush, IDX_W=6 -> busy high exactly 64 cycles, pred/upd ignored, afterwards any pred -> 01.
REQ-032 Assert reset in sweep cycle 10 -> busy=0 immediately, all entries 01.
